// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: registers VGA sync, visible-area, phase and line/frame-end timing
// decoded from the upstream free-running h/v pixel counters.
module vga_sync_decoder #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic [1:0] h_phase,
    output logic [1:0] v_phase,
    output logic       line_end,
    output logic       frame_end,
    output logic       count_err
);
    typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_e;

    localparam logic [10:0] H_A = 11'(H_ACTIVE);
    localparam logic [10:0] H_F = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_S = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_T = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] V_A = 11'(V_ACTIVE);
    localparam logic [10:0] V_F = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_S = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_T = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);

    function automatic phase_e decode(input logic [10:0] c, a, f, s);
        return c < a ? ACTIVE : c < f ? FP : c < s ? SYNC : BP;
    endfunction

    phase_e     h_phase_q, h_phase_d, v_phase_q, v_phase_d, h_dec, v_dec;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic [9:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic       line_end_q, line_end_d, frame_end_q, frame_end_d;
    logic       count_err_q, count_err_d, end_seen_q, end_seen_d;
    logic       oor, h_last, v_last, vis;

    always_comb begin
        oor    = {1'b0, h_cnt} >= H_T || {1'b0, v_cnt} >= V_T;
        h_dec  = decode({1'b0, h_cnt}, H_A, H_F, H_S);
        v_dec  = decode({1'b0, v_cnt}, V_A, V_F, V_S);
        h_last = {1'b0, h_cnt} == H_T - 11'd1;
        v_last = {1'b0, v_cnt} == V_T - 11'd1;
        vis    = h_dec == ACTIVE && v_dec == ACTIVE;
        h_phase_d   = h_phase_q;
        v_phase_d   = v_phase_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        video_on_d  = video_on_q;
        pixel_x_d   = pixel_x_q;
        pixel_y_d   = pixel_y_q;
        count_err_d = count_err_q;
        end_seen_d  = end_seen_q;
        line_end_d  = 1'b0;
        frame_end_d = 1'b0;
        if (enable) begin
            h_phase_d   = oor ? h_phase_q : h_dec;
            v_phase_d   = oor ? v_phase_q : v_dec;
            hsync_d     = !oor && h_dec == SYNC ? SYNC_POL : ~SYNC_POL;
            vsync_d     = !oor && v_dec == SYNC ? SYNC_POL : ~SYNC_POL;
            video_on_d  = !oor && vis;
            pixel_x_d   = !oor && vis ? h_cnt : 10'd0;
            pixel_y_d   = !oor && vis ? v_cnt : 10'd0;
            count_err_d = count_err_q | oor;
            // A count parked on the last pixel only pulses once, on its first sample.
            end_seen_d  = !oor && h_last;
            line_end_d  = !oor && h_last && !end_seen_q;
            frame_end_d = !oor && h_last && !end_seen_q && v_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_phase_q   <= ACTIVE;
            v_phase_q   <= ACTIVE;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            video_on_q  <= 1'b0;
            pixel_x_q   <= 10'd0;
            pixel_y_q   <= 10'd0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            count_err_q <= 1'b0;
            end_seen_q  <= 1'b0;
        end else begin
            h_phase_q   <= h_phase_d;
            v_phase_q   <= v_phase_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_on_q  <= video_on_d;
            pixel_x_q   <= pixel_x_d;
            pixel_y_q   <= pixel_y_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
            count_err_q <= count_err_d;
            end_seen_q  <= end_seen_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign pixel_x   = pixel_x_q;
    assign pixel_y   = pixel_y_q;
    assign h_phase   = h_phase_q;
    assign v_phase   = v_phase_q;
    assign line_end  = line_end_q;
    assign frame_end = frame_end_q;
    assign count_err = count_err_q;
endmodule
